// File: rtl/uart_tx_feeder_if.sv
// Bundles the push side, transmitter handshake and status of the UART TX feeder.
// slave is the feeder's view; master is the view of whatever drives it.
interface uart_tx_feeder_if #(
    parameter int ADDR_W = 4
);
    logic              WrEn;
    logic [7:0]        WrData;
    logic              Full;
    logic              Empty;
    logic [ADDR_W:0]   Count;
    logic [7:0]        TxData;
    logic              TxEn;
    logic              TxDone;
    logic              Busy;
    logic              Overflow;
    logic              TxErr;
    logic              ClrErr;
    logic [1:0]        DbgState;

    modport slave (
        input  WrEn, WrData, TxDone, ClrErr,
        output Full, Empty, Count, TxData, TxEn, Busy, Overflow, TxErr, DbgState
    );

    modport master (
        output WrEn, WrData, TxDone, ClrErr,
        input  Full, Empty, Count, TxData, TxEn, Busy, Overflow, TxErr, DbgState
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus strobe/handshake sequencer feeding an RS-232 transmitter,
// with a watchdog on the TxDone handshake and sticky error flags.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int EN_HOLD = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic              Clk,
    input  logic              Rst_n,
    uart_tx_feeder_if.slave   bus
);

    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STROBE    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok;
    logic              pop;

    logic              sync1_q, done_s_q;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    // FIFO bookkeeping: pops happen only from IDLE with data present.
    always_comb begin
        push_ok  = bus.WrEn && !full_q;
        pop      = (state_q == S_IDLE) && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.WrData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // TxDone comes from the transmitter's Tick domain.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q  <= 1'b0;
            done_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.TxDone;
            done_s_q <= sync1_q;
        end
    end

    // Sequencer; the watchdog wins over a coincident handshake step.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        wd_d        = wd_q;
        tx_data_d   = tx_data_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    hold_d    = HOLD_W'(EN_HOLD - 1);
                    state_d   = S_STROBE;
                end
            end
            S_STROBE: begin
                wd_d = '0;
                if (hold_q == '0) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (done_s_q) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (!done_s_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_en_d = (state_d == S_STROBE);
        busy_d  = (state_d != S_IDLE);

        // Set beats a coincident clear.
        ovf_d = ovf_q;
        err_d = err_q;
        if (bus.ClrErr) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
        end
        if (bus.WrEn && full_q) begin
            ovf_d = 1'b1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            wd_q      <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wd_q      <= wd_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign bus.Full     = full_q;
    assign bus.Empty    = empty_q;
    assign bus.Count    = count_q;
    assign bus.TxData   = tx_data_q;
    assign bus.TxEn     = tx_en_q;
    assign bus.Busy     = busy_q;
    assign bus.Overflow = ovf_q;
    assign bus.TxErr    = err_q;
    assign bus.DbgState = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a transmitter model answers strobes, a scoreboard
// queue holds the bytes expected on TxData in order.
module tb_uart_tx_feeder;

    localparam int ADDR_W = 4;

    logic Clk;
    logic Rst_n;

    uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_feeder #(
        .DEPTH  (16),
        .ADDR_W (ADDR_W),
        .EN_HOLD(2),
        .TIMEOUT(100)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    logic model_on;
    logic model_done;
    logic man_done;
    logic m_busy;
    int   m_wait;
    int   m_len;
    logic prev_en;
    int   hold_cnt;
    int   n_strobe;

    assign bus.TxDone = model_on ? model_done : man_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor + transmitter model, sampled on the falling edge.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_en    = 1'b0;
            hold_cnt   = 0;
            m_busy     = 1'b0;
            model_done = 1'b0;
            m_wait     = 0;
            m_len      = 0;
        end else begin
            if (m_busy) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else if (m_len > 0) begin
                    model_done = 1'b1;
                    m_len--;
                end else begin
                    model_done = 1'b0;
                    m_busy     = 1'b0;
                end
            end
            if (bus.TxEn && !prev_en) begin
                n_strobe++;
                check("no_strobe_while_tx_busy", {31'd0, m_busy}, 32'd0);
                check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("txdata_order", {24'd0, bus.TxData}, {24'd0, exp_q.pop_front()});
                end
                hold_cnt = 1;
                if (model_on) begin
                    m_busy = 1'b1;
                    m_wait = $urandom_range(3, 8);
                    m_len  = $urandom_range(1, 6);
                end
            end else if (bus.TxEn) begin
                hold_cnt++;
            end else if (prev_en) begin
                check("en_hold_len", hold_cnt, 32'd2);
            end
            prev_en = bus.TxEn;
        end
    end

    // driver tasks
    task automatic push(input logic [7:0] b, input bit accept);
        bus.WrEn   = 1'b1;
        bus.WrData = b;
        if (accept) exp_q.push_back(b);
        @(negedge Clk);
        bus.WrEn   = 1'b0;
    endtask

    task automatic wait_en(input logic level, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.TxEn === level) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && bus.Empty && !bus.Busy && !m_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_done(input int cycles);
        man_done = 1'b1;
        repeat (cycles) @(negedge Clk);
        man_done = 1'b0;
    endtask

    initial begin
        int n;
        int peak;
        int s0;
        Rst_n      = 1'b0;
        bus.WrEn   = 1'b0;
        bus.WrData = 8'h00;
        bus.ClrErr = 1'b0;
        man_done   = 1'b0;
        model_on   = 1'b0;
        n_strobe   = 0;
        repeat (3) @(negedge Clk);

        // reset state
        check("rst_empty", {31'd0, bus.Empty}, 32'd1);
        check("rst_full", {31'd0, bus.Full}, 32'd0);
        check("rst_count", {27'd0, bus.Count}, 32'd0);
        check("rst_txen", {31'd0, bus.TxEn}, 32'd0);
        check("rst_txdata", {24'd0, bus.TxData}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_ovf", {31'd0, bus.Overflow}, 32'd0);
        check("rst_txerr", {31'd0, bus.TxErr}, 32'd0);
        check("rst_state", {30'd0, bus.DbgState}, 32'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // single byte with latency and handshake timing
        push(8'hA5, 1'b1);
        check("sb_empty_n1", {31'd0, bus.Empty}, 32'd0);
        check("sb_count_n1", {27'd0, bus.Count}, 32'd1);
        check("sb_txen_n1", {31'd0, bus.TxEn}, 32'd0);
        @(negedge Clk);
        check("sb_txen_n2", {31'd0, bus.TxEn}, 32'd1);
        check("sb_txdata_n2", {24'd0, bus.TxData}, 32'hA5);
        check("sb_busy_n2", {31'd0, bus.Busy}, 32'd1);
        check("sb_count_n2", {27'd0, bus.Count}, 32'd0);
        @(negedge Clk);
        check("sb_txen_n3", {31'd0, bus.TxEn}, 32'd1);
        @(negedge Clk);
        check("sb_txen_n4", {31'd0, bus.TxEn}, 32'd0);
        repeat (38) @(negedge Clk);
        check("sb_busy_wait", {31'd0, bus.Busy}, 32'd1);
        pulse_done(5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n++;
            if (!bus.Busy) break;
        end
        check("sb_busy_drop_delay", n, 32'd3);
        check("sb_count_end", {27'd0, bus.Count}, 32'd0);
        check("sb_txdata_hold", {24'd0, bus.TxData}, 32'hA5);
        check("sb_txerr", {31'd0, bus.TxErr}, 32'd0);

        // burst ordering with the transmitter model
        model_on = 1'b1;
        s0 = n_strobe;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        drain("burst_drain");
        check("burst_strobes", n_strobe - s0, 32'd16);
        check("burst_txerr", {31'd0, bus.TxErr}, 32'd0);

        // full / overflow with a stalled transmitter
        model_on = 1'b0;
        peak = 0;
        for (int i = 0; i < 17; i++) begin
            push(8'h40 + 8'(i), 1'b1);
            if (int'(bus.Count) > peak) peak = int'(bus.Count);
        end
        check("ovf_before", {31'd0, bus.Overflow}, 32'd0);
        check("ovf_full", {31'd0, bus.Full}, 32'd1);
        push(8'hEE, 1'b0);
        if (int'(bus.Count) > peak) peak = int'(bus.Count);
        check("ovf_peak", peak, 32'd16);
        check("ovf_count", {27'd0, bus.Count}, 32'd16);
        check("ovf_set", {31'd0, bus.Overflow}, 32'd1);
        bus.ClrErr = 1'b1;
        @(negedge Clk);
        bus.ClrErr = 1'b0;
        check("ovf_clr", {31'd0, bus.Overflow}, 32'd0);
        bus.ClrErr = 1'b1;
        push(8'hEF, 1'b0);
        bus.ClrErr = 1'b0;
        check("ovf_set_wins", {31'd0, bus.Overflow}, 32'd1);
        bus.ClrErr = 1'b1;
        @(negedge Clk);
        bus.ClrErr = 1'b0;
        check("ovf_clr2", {31'd0, bus.Overflow}, 32'd0);
        model_on = 1'b1;
        drain("ovf_drain");
        check("ovf_drain_txerr", {31'd0, bus.TxErr}, 32'd1);
        bus.ClrErr = 1'b1;
        @(negedge Clk);
        bus.ClrErr = 1'b0;
        check("txerr_clr", {31'd0, bus.TxErr}, 32'd0);

        // timeout: exactly 100 cycles after WAIT_DONE entry
        model_on = 1'b0;
        push(8'h77, 1'b1);
        wait_en(1'b1, "to_strobe_seen");
        wait_en(1'b0, "to_wait_entry");
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            n++;
            if (bus.TxErr) break;
        end
        check("to_cycles", n, 32'd100);
        check("to_idle", {31'd0, bus.Busy}, 32'd0);
        model_on = 1'b1;
        push(8'h78, 1'b1);
        drain("to_next_byte");
        check("to_txerr_sticky", {31'd0, bus.TxErr}, 32'd1);

        // simultaneous push and pop with Count = 3
        model_on = 1'b0;
        push(8'h90, 1'b1);
        wait_en(1'b1, "pp_first_strobe");
        wait_en(1'b0, "pp_first_wait");
        push(8'h91, 1'b1);
        push(8'h92, 1'b1);
        push(8'h93, 1'b1);
        check("pp_count_pre", {27'd0, bus.Count}, 32'd3);
        pulse_done(4);
        for (int i = 0; i < 20; i++) begin
            if (!bus.Busy) break;
            @(negedge Clk);
        end
        model_on = 1'b1;
        push(8'h94, 1'b1);
        check("pp_count_same", {27'd0, bus.Count}, 32'd3);
        check("pp_txen", {31'd0, bus.TxEn}, 32'd1);
        drain("pp_drain");

        // reset mid-STROBE with Count = 5
        model_on = 1'b0;
        push(8'hB0, 1'b1);
        wait_en(1'b1, "rst_first_strobe");
        wait_en(1'b0, "rst_first_wait");
        for (int i = 0; i < 6; i++) push(8'hB1 + 8'(i), 1'b1);
        pulse_done(4);
        wait_en(1'b1, "rst_strobe_again");
        check("rst_pre_count", {27'd0, bus.Count}, 32'd5);
        #2 Rst_n = 1'b0;
        #1;
        check("rst_async_txen", {31'd0, bus.TxEn}, 32'd0);
        check("rst_async_count", {27'd0, bus.Count}, 32'd0);
        check("rst_async_empty", {31'd0, bus.Empty}, 32'd1);
        check("rst_async_busy", {31'd0, bus.Busy}, 32'd0);
        exp_q.delete();
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        s0 = n_strobe;
        repeat (30) @(negedge Clk);
        check("rst_no_strobe", n_strobe - s0, 32'd0);
        model_on = 1'b1;
        push(8'hC3, 1'b1);
        drain("rst_new_byte");
        check("rst_new_strobe", n_strobe - s0, 32'd1);

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO and sequencer placed directly upstream of the RS-232 transmitter.
- Accepts bytes from system logic on a single-cycle push interface and buffers them.
- Presents each byte on TxData, raises a TxEn strobe, then waits for the transmitter's TxDone handshake before issuing the next byte.
- Guards the handshake with a timeout watchdog and sticky error flags.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH).
- EN_HOLD, 2, number of Clk cycles TxEn is held high per byte (at least 1).
- TIMEOUT, 65535, number of Clk cycles allowed in WAIT_DONE plus GAP before the byte is aborted.

Ports:
- Clk  in  1  system clock; every flop in this block is in this domain.
- Rst_n  in  1  asynchronous, active-low reset.
- WrEn  in  1  push strobe; one byte is pushed per high cycle.
- WrData  in  8  byte to push.
- Full  out  1  FIFO holds DEPTH bytes.
- Empty  out  1  FIFO holds 0 bytes.
- Count  out  ADDR_W+1  current FIFO occupancy.
- TxData  out  8  byte presented to the transmitter.
- TxEn  out  1  start strobe to the transmitter (the transmitter detects its rising edge).
- TxDone  in  1  transmitter completion flag; generated in the Tick domain and treated as asynchronous.
- Busy  out  1  FSM is not in IDLE.
- Overflow  out  1  sticky: a push was attempted while Full.
- TxErr  out  1  sticky: a handshake timeout occurred.
- ClrErr  in  1  clears Overflow and TxErr.

Behaviour:
- Reset:
  - FIFO pointers and Count = 0; Empty = 1; Full = 0.
  - TxData = 8'h00; TxEn = 0; Busy = 0; Overflow = 0; TxErr = 0.
  - State = IDLE; TxDone synchroniser flops = 0.
  - Reset mid-transfer discards all buffered bytes and drops TxEn immediately.
- FIFO:
  - Circular buffer with ADDR_W-bit pointers that wrap at DEPTH.
  - Count, Full and Empty are registered and update the cycle after a push or pop.
  - A push is accepted only if Full = 0 at the sampling edge. If Full = 1, the byte is dropped and Overflow is set on the same edge.
  - A push and a pop on the same edge both take effect; Count is unchanged.
  - A pop occurs only in IDLE with Empty = 0, so there is no underflow path.
- TxDone synchronisation:
  - Two-flop synchroniser producing done_s.
  - done_s is the only form of TxDone used by the FSM.
- FSM states:
  - IDLE: if Empty = 0, TxData <= FIFO head, pop, load the hold counter with EN_HOLD-1, go to STROBE. Otherwise stay in IDLE.
  - STROBE: TxEn = 1. Decrement the hold counter; at 0, go to WAIT_DONE. The watchdog is cleared on entry.
  - WAIT_DONE: TxEn = 0. Wait for done_s = 1, then go to GAP.
  - GAP: wait for done_s = 0 (the transmitter has cleared TxDone), then go to IDLE. This guarantees the next TxEn edge reaches a transmitter that is back in IDLE with TxDone low.
  - Timeout: in WAIT_DONE or GAP, the watchdog counts Clk cycles. When it reaches TIMEOUT, set TxErr, go to IDLE, and drop the byte (no retry).
- Outputs:
  - TxEn is registered and glitch-free.
  - TxData is held stable from the STROBE entry edge until the next IDLE-to-STROBE transition.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE gives:
  - Empty = 0 after N+1.
  - TxData valid and TxEn = 1 after N+2.
  - TxEn high for exactly EN_HOLD cycles.
- Busy = 1 in every state except IDLE.
- Sticky flags:
  - ClrErr clears Overflow and TxErr on the next edge.
  - If ClrErr coincides with a set event, the set wins.
- Back-to-back bytes: the minimum spacing between consecutive TxEn rising edges is EN_HOLD + 2 synchroniser delays + the transmitter's TxDone duration + 1 cycle.

Test Plan:
- Single byte: reset, push 8'hA5 at edge 10 -> TxData = 8'hA5 and TxEn = 1 after edge 12, held 2 cycles; model TxDone high 5 cycles starting 40 cycles later -> Busy drops 1 cycle after done_s falls; Count = 0.
- Burst ordering: push 16 bytes 8'h00..8'h0F with a transmitter model attached -> bytes appear on TxData in order 00..0F, one TxEn per byte, no second TxEn while done_s = 1.
- Full/overflow: transmitter stalled (TxDone = 0, TIMEOUT large); push 18 bytes -> byte 0 in flight, Count peaks at 16, Full = 1, the 18th byte is dropped, Overflow = 1; ClrErr pulse -> Overflow = 0.
- Simultaneous push/pop: Count = 3 and the FSM pops in IDLE on the same edge as a push -> Count stays 3; data order is preserved.
- Timeout: TIMEOUT = 100, TxDone held 0 -> TxErr = 1 exactly 100 cycles after WAIT_DONE entry, FSM returns to IDLE, the next byte strobes normally.
- Reset mid-operation: assert Rst_n = 0 during STROBE with Count = 5 -> TxEn = 0, Count = 0, Empty = 1 asynchronously; after release, no TxEn until a new push.
